// File: rtl/plic_core.sv
// plic_core: interrupt-processing core of a RISC-V PLIC (no bus interface).
// Per-source gateway (level/edge capture, pending and in-service tracking) feeding a per-target
// arbiter (enable mask, priority, threshold, highest-priority / lowest-ID selection).
//
// Ports:
//   clk_i         single clock, rising edge
//   rst_ni        synchronous active-low reset
//   intr_src_i    raw interrupt lines, bit k is source ID k+1
//   le_i          per-source trigger mode, 0 = level, 1 = rising edge
//   prio_i        per-source priority, source bit k at [k*PRIOW +: PRIOW]
//   ie_i          per-target enable mask, target t at [t*N_SOURCE +: N_SOURCE]
//   threshold_i   per-target priority threshold
//   claim_i       per-target claim strobe, claims that target's current irq_id_o
//   complete_i    per-target completion strobe
//   complete_id_i per-target ID being completed
//   ip_o          pending bits (registered)
//   irq_o         per-target interrupt request (registered)
//   irq_id_o      per-target winning source ID, 0 when no request (registered)
module plic_core #(
  parameter int unsigned N_SOURCE = 32,
  parameter int unsigned N_TARGET = 1,
  parameter int unsigned MAX_PRIO = 7,
  localparam int unsigned PRIOW = $clog2(MAX_PRIO + 1),
  localparam int unsigned SRCW  = $clog2(N_SOURCE + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [N_SOURCE-1:0]          intr_src_i,
  input  logic [N_SOURCE-1:0]          le_i,
  input  logic [N_SOURCE*PRIOW-1:0]    prio_i,
  input  logic [N_TARGET*N_SOURCE-1:0] ie_i,
  input  logic [N_TARGET*PRIOW-1:0]    threshold_i,
  input  logic [N_TARGET-1:0]          claim_i,
  input  logic [N_TARGET-1:0]          complete_i,
  input  logic [N_TARGET*SRCW-1:0]     complete_id_i,
  output logic [N_SOURCE-1:0]          ip_o,
  output logic [N_TARGET-1:0]          irq_o,
  output logic [N_TARGET*SRCW-1:0]     irq_id_o
);

  logic [N_SOURCE-1:0]       src_q;
  logic [N_SOURCE-1:0]       ip_q, ip_d;
  logic [N_SOURCE-1:0]       ia_q, ia_d;
  logic [N_TARGET-1:0]       irq_q, irq_d;
  logic [N_TARGET*SRCW-1:0]  irq_id_q, irq_id_d;

  logic [N_SOURCE-1:0]       claim_vec;
  logic [N_SOURCE-1:0]       complete_vec;
  logic [N_SOURCE-1:0]       set_vec;

  logic [PRIOW-1:0]          max_prio [N_TARGET];
  logic [SRCW-1:0]           win_id   [N_TARGET];

  // Claim/complete decode. ID 0 never matches a source; IDs above N_SOURCE match nothing.
  always_comb begin
    claim_vec    = '0;
    complete_vec = '0;
    for (int k = 0; k < int'(N_SOURCE); k++) begin
      for (int t = 0; t < int'(N_TARGET); t++) begin
        if (claim_i[t] && (irq_id_q[t*SRCW +: SRCW] == SRCW'(k + 1))) begin
          claim_vec[k] = 1'b1;
        end
        if (complete_i[t] && (complete_id_i[t*SRCW +: SRCW] == SRCW'(k + 1))) begin
          complete_vec[k] = 1'b1;
        end
      end
    end
  end

  // Gateway: pending is only raised while the source is not in service, so a claimed source
  // stays gated until completed. A complete that arrives while still pending is ignored.
  always_comb begin
    set_vec = (le_i & intr_src_i & ~src_q) | (~le_i & intr_src_i);
    ip_d    = (ip_q | (set_vec & ~ia_q & ~ip_q)) & ~(ip_q & claim_vec);
    ia_d    = (ia_q | (set_vec & ~ia_q)) & ~(ia_q & ~ip_q & complete_vec);
  end

  // Arbiter: strict '>' keeps the lowest ID on ties and stops priority-0 sources from winning.
  always_comb begin
    irq_d    = '0;
    irq_id_d = '0;
    for (int t = 0; t < int'(N_TARGET); t++) begin
      max_prio[t] = '0;
      win_id[t]   = '0;
      for (int k = 0; k < int'(N_SOURCE); k++) begin
        if (ip_q[k] && ie_i[t*N_SOURCE + k] &&
            (prio_i[k*PRIOW +: PRIOW] > max_prio[t])) begin
          max_prio[t] = prio_i[k*PRIOW +: PRIOW];
          win_id[t]   = SRCW'(k + 1);
        end
      end
      irq_d[t]                 = max_prio[t] > threshold_i[t*PRIOW +: PRIOW];
      irq_id_d[t*SRCW +: SRCW] = irq_d[t] ? win_id[t] : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      src_q    <= '0;
      ip_q     <= '0;
      ia_q     <= '0;
      irq_q    <= '0;
      irq_id_q <= '0;
    end else begin
      src_q    <= intr_src_i;
      ip_q     <= ip_d;
      ia_q     <= ia_d;
      irq_q    <= irq_d;
      irq_id_q <= irq_id_d;
    end
  end

  assign ip_o     = ip_q;
  assign irq_o    = irq_q;
  assign irq_id_o = irq_id_q;

endmodule

// File: tb/tb_plic_core.sv
// Scoreboard bench for plic_core (N_SOURCE=32, N_TARGET=1, MAX_PRIO=7).
// Stimulus pushes hand-computed expected outputs after each edge; the monitor pops and
// compares on the following falling edge.
module tb_plic_core;

  localparam int NS = 32;
  localparam int PW = 3;
  localparam int SW = 6;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [NS-1:0] intr_src_i;
  logic [NS-1:0] le_i;
  logic [NS*PW-1:0] prio_i;
  logic [NS-1:0] ie_i;
  logic [PW-1:0] threshold_i;
  logic [0:0]    claim_i;
  logic [0:0]    complete_i;
  logic [SW-1:0] complete_id_i;
  logic [NS-1:0] ip_o;
  logic [0:0]    irq_o;
  logic [SW-1:0] irq_id_o;

  plic_core dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .intr_src_i    (intr_src_i),
    .le_i          (le_i),
    .prio_i        (prio_i),
    .ie_i          (ie_i),
    .threshold_i   (threshold_i),
    .claim_i       (claim_i),
    .complete_i    (complete_i),
    .complete_id_i (complete_id_i),
    .ip_o          (ip_o),
    .irq_o         (irq_o),
    .irq_id_o      (irq_id_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [NS-1:0] ip;
    logic          irq;
    logic [SW-1:0] id;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  // Monitor: outputs are always presented, one queued expectation is checked per falling edge.
  always @(negedge clk_i) begin
    if (exp_q.size() != 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      n_cmp++;
      if (ip_o !== e.ip) begin
        n_fail++;
        $display("FAIL %s ip_o: got %h want %h", n, ip_o, e.ip);
      end
      n_cmp++;
      if (irq_o[0] !== e.irq) begin
        n_fail++;
        $display("FAIL %s irq_o: got %b want %b", n, irq_o[0], e.irq);
      end
      n_cmp++;
      if (irq_id_o !== e.id) begin
        n_fail++;
        $display("FAIL %s irq_id_o: got %0d want %0d", n, irq_id_o, e.id);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_out(input logic [NS-1:0] ip, input logic irq, input int id,
                            input string name);
    exp_t e;
    e.ip  = ip;
    e.irq = irq;
    e.id  = SW'(id);
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic set_prio(input int id, input int val);
    prio_i[(id-1)*PW +: PW] = PW'(val);
  endtask

  task automatic claim_cycle();
    claim_i = 1'b1;
    step();
    claim_i = 1'b0;
  endtask

  task automatic complete_cycle(input int id);
    complete_i    = 1'b1;
    complete_id_i = SW'(id);
    step();
    complete_i    = 1'b0;
    complete_id_i = '0;
  endtask

  localparam logic [NS-1:0] B3  = 32'h0000_0004;
  localparam logic [NS-1:0] B4  = 32'h0000_0008;
  localparam logic [NS-1:0] B5  = 32'h0000_0010;
  localparam logic [NS-1:0] B7  = 32'h0000_0040;
  localparam logic [NS-1:0] B10 = 32'h0000_0200;
  localparam logic [NS-1:0] B12 = 32'h0000_0800;

  initial begin
    rst_ni        = 1'b0;
    intr_src_i    = '0;
    le_i          = '0;
    prio_i        = '0;
    ie_i          = '1;
    threshold_i   = 3'd2;
    claim_i       = 1'b0;
    complete_i    = 1'b0;
    complete_id_i = '0;
    set_prio(3, 5);
    set_prio(4, 3);
    set_prio(5, 4);
    set_prio(7, 6);
    set_prio(10, 4);
    set_prio(12, 0);
    ie_i[9] = 1'b0;
    le_i[4] = 1'b1;

    step();
    step();
    expect_out('0, 1'b0, 0, "reset");
    rst_ni = 1'b1;
    step();
    expect_out('0, 1'b0, 0, "idle");

    // Level source 3
    intr_src_i[2] = 1'b1;
    step(); expect_out(B3, 1'b0, 0, "lvl_pend");
    step(); expect_out(B3, 1'b1, 3, "lvl_irq");
    claim_cycle(); expect_out('0, 1'b1, 3, "claim_lat");
    step(); expect_out('0, 1'b0, 0, "claim_clr");
    step(); expect_out('0, 1'b0, 0, "no_repend");
    complete_cycle(3); expect_out('0, 1'b0, 0, "cmp_lat");
    step(); expect_out(B3, 1'b0, 0, "repend");
    step(); expect_out(B3, 1'b1, 3, "repend_irq");
    claim_cycle(); expect_out('0, 1'b1, 3, "claim2");
    intr_src_i[2] = 1'b0;
    step(); expect_out('0, 1'b0, 0, "claim2_clr");
    complete_cycle(3);
    step(); expect_out('0, 1'b0, 0, "idle_after_cmp");

    // Priority, tie-break, threshold
    intr_src_i[3] = 1'b1;
    intr_src_i[6] = 1'b1;
    step(); expect_out(B4 | B7, 1'b0, 0, "two_pend");
    step(); expect_out(B4 | B7, 1'b1, 7, "prio_win");
    set_prio(7, 3);
    step(); expect_out(B4 | B7, 1'b1, 4, "tie_low");
    set_prio(7, 6);
    threshold_i = 3'd6;
    step(); expect_out(B4 | B7, 1'b0, 0, "thresh");
    threshold_i = 3'd2;
    step(); expect_out(B4 | B7, 1'b1, 7, "thresh_back");
    intr_src_i[3] = 1'b0;
    intr_src_i[6] = 1'b0;
    claim_cycle(); expect_out(B4, 1'b1, 7, "claim7");
    step(); expect_out(B4, 1'b1, 4, "switch4");
    claim_cycle(); expect_out('0, 1'b1, 4, "claim4");
    step(); expect_out('0, 1'b0, 0, "both_claimed");
    complete_cycle(7);
    complete_cycle(4);
    step(); expect_out('0, 1'b0, 0, "both_done");

    // Edge source 5
    intr_src_i[4] = 1'b1;
    step(); expect_out(B5, 1'b0, 0, "edge_pend");
    step(); expect_out(B5, 1'b1, 5, "edge_irq");
    step(); expect_out(B5, 1'b1, 5, "edge_hold");
    claim_cycle(); expect_out('0, 1'b1, 5, "edge_claim");
    step(); expect_out('0, 1'b0, 0, "edge_claimed");
    complete_cycle(5); expect_out('0, 1'b0, 0, "edge_cmp");
    for (int i = 0; i < 4; i++) begin
      step(); expect_out('0, 1'b0, 0, "edge_high_no_pend");
    end
    intr_src_i[4] = 1'b0;
    step(); expect_out('0, 1'b0, 0, "edge_low");
    intr_src_i[4] = 1'b1;
    step(); expect_out(B5, 1'b0, 0, "edge_re");
    step(); expect_out(B5, 1'b1, 5, "edge_re_irq");
    intr_src_i[4] = 1'b0;
    claim_cycle();
    complete_cycle(5);
    step(); expect_out('0, 1'b0, 0, "edge_done");

    // Disabled source 10, then enabled
    intr_src_i[9] = 1'b1;
    step(); expect_out(B10, 1'b0, 0, "dis_pend");
    step(); expect_out(B10, 1'b0, 0, "disabled");
    ie_i[9] = 1'b1;
    step(); expect_out(B10, 1'b1, 10, "enable");
    intr_src_i[9] = 1'b0;
    claim_cycle();
    complete_cycle(10);
    step(); expect_out('0, 1'b0, 0, "dis_done");

    // Priority 0 with threshold 0
    threshold_i = 3'd0;
    intr_src_i[11] = 1'b1;
    step(); expect_out(B12, 1'b0, 0, "prio0_pend");
    step(); expect_out(B12, 1'b0, 0, "prio0");
    step(); expect_out(B12, 1'b0, 0, "prio0_hold");

    // Invalid completion IDs must not release in-service source 3
    intr_src_i[2] = 1'b1;
    step(); expect_out(B3 | B12, 1'b0, 0, "s3_pend");
    step(); expect_out(B3 | B12, 1'b1, 3, "s3_irq");
    claim_cycle(); expect_out(B12, 1'b1, 3, "s3_claim");
    step(); expect_out(B12, 1'b0, 0, "s3_claimed");
    complete_cycle(0); expect_out(B12, 1'b0, 0, "cid0");
    complete_cycle(33); expect_out(B12, 1'b0, 0, "cid33");
    complete_cycle(35); expect_out(B12, 1'b0, 0, "cid35");
    step(); expect_out(B12, 1'b0, 0, "cid_bad");
    step(); expect_out(B12, 1'b0, 0, "cid_bad2");
    complete_cycle(3); expect_out(B12, 1'b0, 0, "cid3");
    step(); expect_out(B3 | B12, 1'b0, 0, "s3_repend");
    step(); expect_out(B3 | B12, 1'b1, 3, "s3_re_irq");

    // Synchronous reset mid-activity
    rst_ni = 1'b0;
    step(); expect_out('0, 1'b0, 0, "rst_mid");
    intr_src_i = '0;
    step(); expect_out('0, 1'b0, 0, "rst_hold");
    rst_ni = 1'b1;
    step(); expect_out('0, 1'b0, 0, "rst_release");

    // Claim and complete of the same source in one cycle
    intr_src_i[2] = 1'b1;
    step(); expect_out(B3, 1'b0, 0, "cc_pend");
    step(); expect_out(B3, 1'b1, 3, "cc_irq");
    claim_i       = 1'b1;
    complete_i    = 1'b1;
    complete_id_i = SW'(3);
    step();
    claim_i       = 1'b0;
    complete_i    = 1'b0;
    complete_id_i = '0;
    expect_out('0, 1'b1, 3, "cc_same");
    step(); expect_out('0, 1'b0, 0, "cc_gated");
    step(); expect_out('0, 1'b0, 0, "cc_gated2");

    @(negedge clk_i);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, want finish");
    $fatal(1, "watchdog");
  end

endmodule
